// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register-file port controller and its arbiter.
package regfile_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  typedef enum logic {GNT_A, GNT_B}    grant_e;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Handshake and RegisterFile control bundle between the execute/load stages, the
// port controller, and the register file.
interface regfile_port_arbiter_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);
  logic              wa_valid;
  logic              wa_ready;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_src1;
  logic [ADDR_W-1:0] rd_src2;
  logic              rd_done;
  logic              init_done;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_destin;
  logic [DATA_W-1:0] rf_datain;
  logic              rf_read;
  logic [ADDR_W-1:0] rf_source1;
  logic [ADDR_W-1:0] rf_source2;

  modport master (
    output wa_valid, wa_addr, wa_data,
    output wb_valid, wb_addr, wb_data,
    output rd_valid, rd_src1, rd_src2,
    input  wa_ready, wb_ready, rd_ready, rd_done, init_done,
    input  rf_write, rf_destin, rf_datain, rf_read, rf_source1, rf_source2
  );

  modport slave (
    input  wa_valid, wa_addr, wa_data,
    input  wb_valid, wb_addr, wb_data,
    input  rd_valid, rd_src1, rd_src2,
    output wa_ready, wb_ready, rd_ready, rd_done, init_done,
    output rf_write, rf_destin, rf_datain, rf_read, rf_source1, rf_source2
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic               req_a_i,
  input  logic               req_b_i,
  input  regfile_pkg::grant_e last_grant_i,
  output logic               gnt_a_o,
  output logic               gnt_b_o
);
  import regfile_pkg::*;

  always_comb begin
    gnt_a_o = req_a_i && (!req_b_i || (last_grant_i == GNT_B));
    gnt_b_o = req_b_i && (!req_a_i || (last_grant_i == GNT_A));
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// RegisterFile front-end: clears every register after reset, then arbitrates the write
// port between two requesters and pipelines a single read client onto the read port.
module regfile_port_arbiter #(
  parameter int                       DATA_W     = regfile_pkg::DATA_W,
  parameter int                       ADDR_W     = regfile_pkg::ADDR_W,
  parameter int                       NUM_REGS   = regfile_pkg::NUM_REGS,
  parameter logic [DATA_W-1:0]        INIT_VALUE = '0
) (
  input logic                   clk,
  input logic                   Reset_n,
  regfile_port_arbiter_if.slave bus
);
  import regfile_pkg::*;

  localparam int CNT_W = ADDR_W + 1;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  grant_e            last_grant_q;
  logic              rf_write_q;
  logic [ADDR_W-1:0] rf_destin_q;
  logic [DATA_W-1:0] rf_datain_q;
  logic              rf_read_q;
  logic [ADDR_W-1:0] rf_source1_q;
  logic [ADDR_W-1:0] rf_source2_q;
  logic              rd_done_q;
  logic              init_done_q;

  logic              gnt_a;
  logic              gnt_b;
  logic              run;
  logic              wr_xfer;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              raw_hit;
  logic              rd_xfer;

  rr_arbiter2 u_arb (
    .req_a_i      (bus.wa_valid),
    .req_b_i      (bus.wb_valid),
    .last_grant_i (last_grant_q),
    .gnt_a_o      (gnt_a),
    .gnt_b_o      (gnt_b)
  );

  // A read naming the register being written this cycle would sample the old value,
  // so it is held off for one cycle.
  always_comb begin
    run     = (state_q == ST_RUN);
    wr_xfer = run && (gnt_a || gnt_b);
    wr_addr = gnt_a ? bus.wa_addr : bus.wb_addr;
    wr_data = gnt_a ? bus.wa_data : bus.wb_data;
    raw_hit = wr_xfer && ((wr_addr == bus.rd_src1) || (wr_addr == bus.rd_src2));
    rd_xfer = run && bus.rd_valid && !raw_hit;
  end

  assign bus.wa_ready   = run && gnt_a;
  assign bus.wb_ready   = run && gnt_b;
  assign bus.rd_ready   = rd_xfer;
  assign bus.rd_done    = rd_done_q;
  assign bus.init_done  = init_done_q;
  assign bus.rf_write   = rf_write_q;
  assign bus.rf_destin  = rf_destin_q;
  assign bus.rf_datain  = rf_datain_q;
  assign bus.rf_read    = rf_read_q;
  assign bus.rf_source1 = rf_source1_q;
  assign bus.rf_source2 = rf_source2_q;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      last_grant_q <= GNT_B;
      rf_write_q   <= 1'b0;
      rf_destin_q  <= '0;
      rf_datain_q  <= '0;
      rf_read_q    <= 1'b0;
      rf_source1_q <= '0;
      rf_source2_q <= '0;
      rd_done_q    <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      rd_done_q <= rf_read_q;
      rf_read_q <= rd_xfer;
      if (rd_xfer) begin
        rf_source1_q <= bus.rd_src1;
        rf_source2_q <= bus.rd_src2;
      end

      case (state_q)
        ST_INIT: begin
          rf_write_q  <= 1'b1;
          rf_destin_q <= cnt_q[ADDR_W-1:0];
          rf_datain_q <= INIT_VALUE;
          cnt_q       <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_REGS - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          rf_write_q <= wr_xfer;
          if (wr_xfer) begin
            rf_destin_q  <= wr_addr;
            rf_datain_q  <= wr_data;
            last_grant_q <= gnt_a ? GNT_A : GNT_B;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench: controller plus a behavioural RegisterFile, checked cycle by cycle against a
// reference model built from the handshake rules and a shadow copy of register contents.
module tb_regfile_port_arbiter;
  import regfile_pkg::*;

  localparam int NR = NUM_REGS;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  logic poison = 1'b0;
  always #5 clk = ~clk;

  regfile_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_port_arbiter #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_REGS   (NUM_REGS),
    .INIT_VALUE (8'h00)
  ) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Behavioural RegisterFile: synchronous write and synchronous two-port read.
  logic [7:0] rf_mem [16];
  logic [7:0] Dataout1, Dataout2;
  always @(posedge clk) begin
    if (poison) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 8'hEE;
    end else if (bus.rf_write) begin
      rf_mem[bus.rf_destin] <= bus.rf_datain;
    end
    if (bus.rf_read) begin
      Dataout1 <= rf_mem[bus.rf_source1];
      Dataout2 <= rf_mem[bus.rf_source2];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         c;
  bit         m_last_b;
  logic [7:0] ref_mem [16];
  bit         pw;
  logic [3:0] pw_addr, m_destin;
  logic [7:0] pw_data, m_datain;
  bit         s1v, s2v;
  logic [3:0] s1a, s1b, m_src1, m_src2;
  logic [7:0] s1d1, s1d2, s2d1, s2d2;
  bit         last_ea, last_eb, last_er;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    c = 0;
    m_last_b = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    pw = 1'b0; pw_addr = '0; pw_data = '0;
    m_destin = '0; m_datain = '0;
    s1v = 1'b0; s2v = 1'b0;
    s1a = '0; s1b = '0; s1d1 = '0; s1d2 = '0; s2d1 = '0; s2d2 = '0;
    m_src1 = '0; m_src2 = '0;
    last_ea = 1'b0; last_eb = 1'b0; last_er = 1'b0;
  endtask

  task automatic drive_idle();
    bus.wa_valid = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.rd_valid = 1'b0; bus.rd_src1 = '0; bus.rd_src2 = '0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rf_write"}, bus.rf_write, 0);
    check({tag, "_rf_destin"}, bus.rf_destin, 0);
    check({tag, "_rf_datain"}, bus.rf_datain, 0);
    check({tag, "_rf_read"}, bus.rf_read, 0);
    check({tag, "_rf_src"}, {bus.rf_source1, bus.rf_source2}, 0);
    check({tag, "_rd_done"}, bus.rd_done, 0);
    check({tag, "_init_done"}, bus.init_done, 0);
    check({tag, "_readies"}, {bus.wa_ready, bus.wb_ready, bus.rd_ready}, 0);
  endtask

  // Returns at posedge+1 with the model positioned at cycle 0 after release.
  task automatic apply_reset(input bit do_poison);
    Reset_n = 1'b0;
    drive_idle();
    poison = do_poison;
    repeat (2) @(posedge clk);
    #1;
    poison = 1'b0;
    check_zero_outputs("rst");
    Reset_n = 1'b1;
    mdl_reset();
  endtask

  // One clock cycle: inputs already driven; compare at the falling edge, then advance the model.
  task automatic tick();
    bit run, ea, eb, wt, er, ewr;
    logic [3:0] wad, s1, s2;
    logic [7:0] wd;
    @(negedge clk);
    s1  = bus.rd_src1;
    s2  = bus.rd_src2;
    run = (c >= NR);
    ea  = run && bus.wa_valid && (!bus.wb_valid || m_last_b);
    eb  = run && bus.wb_valid && (!bus.wa_valid || !m_last_b);
    wt  = ea || eb;
    wad = ea ? bus.wa_addr : bus.wb_addr;
    wd  = ea ? bus.wa_data : bus.wb_data;
    er  = run && bus.rd_valid && !(wt && (wad == s1 || wad == s2));

    if (c >= 1 && c <= NR) begin
      ewr = 1'b1; m_destin = 4'(c - 1); m_datain = 8'h00;
    end else begin
      ewr = pw;
      if (pw) begin m_destin = pw_addr; m_datain = pw_data; end
    end
    if (s1v) begin m_src1 = s1a; m_src2 = s1b; end

    check("wa_ready", bus.wa_ready, ea);
    check("wb_ready", bus.wb_ready, eb);
    check("rd_ready", bus.rd_ready, er);
    check("rf_write", bus.rf_write, ewr);
    check("rf_destin", bus.rf_destin, m_destin);
    check("rf_datain", bus.rf_datain, m_datain);
    check("rf_read", bus.rf_read, s1v);
    check("rf_sources", {bus.rf_source1, bus.rf_source2}, {m_src1, m_src2});
    check("rd_done", bus.rd_done, s2v);
    check("init_done", bus.init_done, (c >= NR));
    if (s2v) begin
      check("Dataout1", Dataout1, s2d1);
      check("Dataout2", Dataout2, s2d2);
    end

    s2v = s1v; s2d1 = s1d1; s2d2 = s1d2;
    s1v = er;
    if (er) begin s1a = s1; s1b = s2; s1d1 = ref_mem[s1]; s1d2 = ref_mem[s2]; end
    if (wt) begin ref_mem[wad] = wd; m_last_b = eb; end
    pw = wt; pw_addr = wad; pw_data = wd;
    last_ea = ea; last_eb = eb; last_er = er;
    c++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [3:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return 4'($urandom_range(0, 3));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    // Sweep after reset, then every register reads back cleared.
    apply_reset(1'b1);
    idle_ticks(NR + 2);
    for (int i = 0; i < NR; i++) begin
      bus.rd_valid = 1'b1; bus.rd_src1 = 4'(i); bus.rd_src2 = 4'(NR - 1 - i);
      tick();
    end
    idle_ticks(3);

    // A then B writes, then one read of both.
    bus.wa_valid = 1'b1; bus.wa_addr = 4'd3; bus.wa_data = 8'hAA; tick();
    drive_idle(); bus.wb_valid = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 8'h55; tick();
    drive_idle(); bus.rd_valid = 1'b1; bus.rd_src1 = 4'd3; bus.rd_src2 = 4'd7; tick();
    idle_ticks(3);

    // Contention held for four cycles alternates grants.
    bus.wa_valid = 1'b1; bus.wa_addr = 4'd1; bus.wa_data = 8'h11;
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd2; bus.wb_data = 8'h22;
    repeat (4) tick();
    idle_ticks(2);

    // Read of the register being written in the same cycle stalls one cycle.
    bus.wa_valid = 1'b1; bus.wa_addr = 4'd5; bus.wa_data = 8'h3C;
    bus.rd_valid = 1'b1; bus.rd_src1 = 4'd5; bus.rd_src2 = 4'd0;
    tick();
    bus.wa_valid = 1'b0;
    tick();
    idle_ticks(3);

    // Asynchronous reset in the middle of a write burst.
    bus.wa_valid = 1'b1; bus.wa_addr = 4'd3; bus.wa_data = 8'hAA;
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd9; bus.wb_data = 8'h99;
    repeat (3) tick();
    #2 Reset_n = 1'b0;
    #1 check_zero_outputs("async");
    @(posedge clk); #1;
    drive_idle();
    Reset_n = 1'b1;
    mdl_reset();
    idle_ticks(NR + 1);
    bus.rd_valid = 1'b1; bus.rd_src1 = 4'd3; bus.rd_src2 = 4'd9; tick();
    idle_ticks(3);

    // Write requested throughout the sweep is taken on the first RUN cycle.
    apply_reset(1'b0);
    bus.wa_valid = 1'b1; bus.wa_addr = 4'd12; bus.wa_data = 8'hC3;
    for (int i = 0; i <= NR; i++) tick();
    check("init_write_taken", last_ea, 1);
    drive_idle(); tick();
    bus.rd_valid = 1'b1; bus.rd_src1 = 4'd12; bus.rd_src2 = 4'd12; tick();
    idle_ticks(3);

    // Random traffic; requesters hold their request until accepted.
    for (int k = 0; k < 600; k++) begin
      if (!bus.wa_valid || last_ea) begin
        bus.wa_valid = ($urandom_range(0, 2) != 0);
        bus.wa_addr = rand_addr(); bus.wa_data = 8'($urandom);
      end
      if (!bus.wb_valid || last_eb) begin
        bus.wb_valid = ($urandom_range(0, 2) != 0);
        bus.wb_addr = rand_addr(); bus.wb_data = 8'($urandom);
      end
      if (!bus.rd_valid || last_er) begin
        bus.rd_valid = ($urandom_range(0, 1) != 0);
        bus.rd_src1 = rand_addr(); bus.rd_src2 = rand_addr();
      end
      tick();
    end
    idle_ticks(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
